// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart transmit path among N byte producers,
// supporting locked multi-byte bursts and recovery from a uart that never goes busy.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic           transmit,
  output logic [7:0]     data_tx,
  input  logic           busy_tx
);
  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_n;
  logic [N-1:0]     grant_n, ack_n;
  logic             err_n, transmit_n;
  logic [7:0]       data_tx_n;
  logic [PTR_W-1:0] ptr, ptr_n, owner, owner_n, sel;
  logic             sel_vld;
  logic [CNT_W-1:0] cnt, cnt_n;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N) sum = sum - N;
    return PTR_W'(sum);
  endfunction

  // Scan from the far end back toward ptr so the closest requester wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr_add(ptr, k)]) begin
        sel     = ptr_add(ptr, k);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    ack_n      = '0;
    err_n      = 1'b0;
    transmit_n = 1'b0;
    data_tx_n  = data_tx;
    ptr_n      = ptr;
    owner_n    = owner;
    cnt_n      = cnt;
    case (state)
      IDLE: begin
        if (!busy_tx && sel_vld) begin
          owner_n      = sel;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          data_tx_n    = data[{sel, 3'b000} +: 8];
          state_n      = LAUNCH;
        end
      end
      LAUNCH: begin
        transmit_n = 1'b1;
        cnt_n      = '0;
        state_n    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_tx) begin
          ack_n   = grant;
          state_n = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          grant_n = '0;
          ptr_n   = ptr_add(owner, 1);
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        // A locked owner with another byte pending keeps the path without rearbitration.
        if (!busy_tx) begin
          if (lock[owner] && req[owner]) begin
            data_tx_n = data[{owner, 3'b000} +: 8];
            state_n   = LAUNCH;
          end else begin
            grant_n = '0;
            ptr_n   = ptr_add(owner, 1);
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      transmit <= 1'b0;
      data_tx  <= 8'h00;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ack      <= ack_n;
      err      <= err_n;
      transmit <= transmit_n;
      data_tx  <= data_tx_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a simple uart busy model,
// and a transaction-level round-robin/burst reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N            = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic           clk  = 1'b0;
  logic           nRst = 1'b1;
  logic [N-1:0]   req  = '0;
  logic [N-1:0]   lock = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   grant, ack;
  logic           err, transmit;
  logic [7:0]     data_tx;
  logic           busy_tx = 1'b0;

  uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .nRst(nRst), .req(req), .lock(lock), .data(data),
    .grant(grant), .ack(ack), .err(err), .transmit(transmit),
    .data_tx(data_tx), .busy_tx(busy_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] qmem [N][16];
  int         qhead [N];
  int         qlen [N];
  bit         burst [N];
  int         m_ptr;
  int         exp_owner[$];
  logic [7:0] exp_data[$];
  int         log_owner[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         ack_owner[$];
  int         ack_cyc[$];
  int         err_cyc[$];
  int         busy_cnt;
  bit         pending, hold_busy, model_en, inflight;
  int         proto_viol;
  int         n_checks, n_pass;

  function automatic int oh_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (qlen[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      qlen[i] = 0; qhead[i] = 0; burst[i] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    log_owner.delete(); log_data.delete(); log_cyc.delete();
    ack_owner.delete(); ack_cyc.delete(); err_cyc.delete();
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i]          = (qlen[i] > 0);
      lock[i]         = burst[i] && (qlen[i] > 0);
      data[8*i +: 8]  = qmem[i][qhead[i]];
    end
  endtask

  // One cycle: observe outputs, advance the uart model, update the requesters.
  task automatic step();
    int o;
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (pending) begin busy_cnt = 10; pending = 1'b0; end
    if (transmit) begin
      if (inflight) proto_viol++;
      inflight = 1'b1;
      log_owner.push_back(oh_idx(grant));
      log_data.push_back(data_tx);
      log_cyc.push_back(cyc);
      if (model_en) pending = 1'b1;
    end
    if (ack != '0) begin
      o = oh_idx(ack);
      ack_owner.push_back(o);
      ack_cyc.push_back(cyc);
      if (err || o < 0) proto_viol++;
      inflight = 1'b0;
      if (o >= 0 && qlen[o] > 0) begin qhead[o]++; qlen[o]--; end
    end
    if (err) begin err_cyc.push_back(cyc); inflight = 1'b0; end
    busy_tx = hold_busy || (busy_cnt > 0);
    drive_reqs();
  endtask

  task automatic run_traffic(input int max_cycles, input int stop_launches, output bit done);
    int idle;
    idle = 0;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      if (stop_launches > 0) begin
        if (log_owner.size() >= stop_launches) done = 1'b1;
      end else begin
        if (queues_empty() && grant == '0 && !busy_tx && busy_cnt == 0 && !pending) idle++;
        else idle = 0;
        if (idle >= 3) done = 1'b1;
      end
    end
  endtask

  // Launch order implied by round-robin from m_ptr plus lock continuation.
  task automatic model_sequence();
    int len [N];
    int head [N];
    int cont, o, left;
    exp_owner.delete(); exp_data.delete();
    cont = -1; left = 0;
    for (int i = 0; i < N; i++) begin len[i] = qlen[i]; head[i] = qhead[i]; left += qlen[i]; end
    while (left > 0) begin
      if (cont >= 0) o = cont;
      else begin
        o = -1;
        for (int k = 0; k < N; k++) if (o < 0 && len[(m_ptr + k) % N] > 0) o = (m_ptr + k) % N;
      end
      exp_owner.push_back(o);
      exp_data.push_back(qmem[o][head[o]]);
      head[o]++; len[o]--; left--;
      if (burst[o] && len[o] > 0) cont = o;
      else begin cont = -1; m_ptr = (o + 1) % N; end
    end
  endtask

  task automatic pulse_reset();
    nRst = 1'b1;
    clear_queues(); drive_reqs();
    busy_cnt = 0; pending = 1'b0; hold_busy = 1'b0; inflight = 1'b0; busy_tx = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic compare_sequence(input string name);
    int a;
    n_checks++;
    if (log_owner.size() != exp_owner.size())
      $display("FAIL %s_launches: got %0d launches expected %0d", name, log_owner.size(), exp_owner.size());
    else n_pass++;
    n_checks++;
    if (ack_owner.size() != exp_owner.size())
      $display("FAIL %s_acks: got %0d acks expected %0d", name, ack_owner.size(), exp_owner.size());
    else n_pass++;
    for (int k = 0; k < exp_owner.size() && k < log_owner.size(); k++) begin
      n_checks++;
      if (log_owner[k] !== exp_owner[k] || log_data[k] !== exp_data[k])
        $display("FAIL %s_launch%0d: got owner %0d data %h expected owner %0d data %h",
                 name, k, log_owner[k], log_data[k], exp_owner[k], exp_data[k]);
      else n_pass++;
      a = (k < ack_owner.size()) ? ack_owner[k] : -2;
      n_checks++;
      if (a !== exp_owner[k]) $display("FAIL %s_ack%0d: got %0d expected %0d", name, k, a, exp_owner[k]);
      else n_pass++;
    end
    n_checks++;
    if (err_cyc.size() != 0) $display("FAIL %s_err: got %0d err pulses expected 0", name, err_cyc.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    req = '1; lock = '1; data = {N{8'hA5}};
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== '0) $display("FAIL reset_grant: got %b expected 0", grant); else n_pass++;
    n_checks++; if (ack !== '0) $display("FAIL reset_ack: got %b expected 0", ack); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (transmit !== 1'b0) $display("FAIL reset_transmit: got %b expected 0", transmit); else n_pass++;
    n_checks++; if (data_tx !== 8'h00) $display("FAIL reset_data_tx: got %h expected 00", data_tx); else n_pass++;
    clear_queues(); drive_reqs();
    nRst = 1'b0; m_ptr = 0;
    @(negedge clk);
    n_checks++; if (grant !== '0) $display("FAIL idle_grant: got %b expected 0", grant); else n_pass++;
  endtask

  task automatic test_single();
    bit done;
    int c0, t0, a0;
    clear_logs();
    qlen[0] = 1; qhead[0] = 0; qmem[0][0] = 8'h55;
    model_sequence();
    drive_reqs();
    c0 = cyc;
    run_traffic(200, 0, done);
    n_checks++; if (!done) $display("FAIL single_done: got not idle expected idle"); else n_pass++;
    compare_sequence("single");
    t0 = (log_cyc.size() > 0) ? log_cyc[0] - c0 : -1;
    n_checks++; if (t0 != 2) $display("FAIL single_launch_latency: got %0d expected 2", t0); else n_pass++;
    a0 = (log_cyc.size() > 0 && ack_cyc.size() > 0) ? ack_cyc[0] - log_cyc[0] : -1;
    n_checks++; if (a0 != 2) $display("FAIL single_ack_latency: got %0d expected 2", a0); else n_pass++;
    n_checks++; if (grant !== '0) $display("FAIL single_grant_after: got %b expected 0", grant); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit done;
    pulse_reset();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      qhead[i] = 0; qlen[i] = 1; qmem[i][0] = 8'h10 + 8'(i);
    end
    model_sequence();
    drive_reqs();
    run_traffic(400, 0, done);
    n_checks++; if (!done) $display("FAIL rr_done: got not idle expected idle"); else n_pass++;
    compare_sequence("rr");
  endtask

  task automatic test_fairness();
    bit done;
    clear_logs();
    qhead[0] = 0; qlen[0] = 3; qhead[2] = 0; qlen[2] = 3;
    for (int j = 0; j < 3; j++) begin qmem[0][j] = 8'h20 + 8'(j); qmem[2][j] = 8'h40 + 8'(j); end
    model_sequence();
    drive_reqs();
    run_traffic(500, 0, done);
    n_checks++; if (!done) $display("FAIL fair_done: got not idle expected idle"); else n_pass++;
    compare_sequence("fair");
  endtask

  task automatic test_burst();
    bit done;
    int g1, g2, g3;
    clear_logs();
    qhead[0] = 0; qlen[0] = 1; qmem[0][0] = 8'h77;
    model_sequence(); drive_reqs();
    run_traffic(200, 0, done);
    compare_sequence("burst_pre");
    clear_logs();
    qhead[1] = 0; qlen[1] = 3; burst[1] = 1'b1;
    qmem[1][0] = 8'hA1; qmem[1][1] = 8'hA2; qmem[1][2] = 8'hA3;
    qhead[0] = 0; qlen[0] = 1; qmem[0][0] = 8'h5A;
    model_sequence(); drive_reqs();
    run_traffic(500, 0, done);
    burst[1] = 1'b0;
    n_checks++; if (!done) $display("FAIL burst_done: got not idle expected idle"); else n_pass++;
    compare_sequence("burst");
    g1 = (log_cyc.size() == 4) ? log_cyc[1] - log_cyc[0] : -1;
    g2 = (log_cyc.size() == 4) ? log_cyc[2] - log_cyc[1] : -1;
    g3 = (log_cyc.size() == 4) ? log_cyc[3] - log_cyc[2] : -1;
    n_checks++; if (g1 != 13 || g2 != 13) $display("FAIL burst_gap: got %0d,%0d expected 13,13", g1, g2); else n_pass++;
    n_checks++; if (g3 != 14) $display("FAIL burst_handoff_gap: got %0d expected 14", g3); else n_pass++;
  endtask

  task automatic test_timeout();
    bit done;
    int o0, o1, d0, e0, e1, r1;
    pulse_reset();
    clear_logs();
    model_en = 1'b0;
    qhead[0] = 0; qlen[0] = 1; qmem[0][0] = 8'h31;
    qhead[1] = 0; qlen[1] = 1; qmem[1][0] = 8'h32;
    drive_reqs();
    run_traffic(200, 2, done);
    n_checks++; if (!done) $display("FAIL to_second_launch: got none expected launch"); else n_pass++;
    o0 = (log_owner.size() > 0) ? log_owner[0] : -2;
    o1 = (log_owner.size() > 1) ? log_owner[1] : -2;
    d0 = (log_data.size() > 0) ? int'(log_data[0]) : -2;
    n_checks++; if (o0 != 0 || o1 != 1) $display("FAIL to_order: got %0d,%0d expected 0,1", o0, o1); else n_pass++;
    n_checks++; if (d0 != 8'h31) $display("FAIL to_data: got %h expected 31", d0); else n_pass++;
    e0 = (err_cyc.size() > 0 && log_cyc.size() > 0) ? err_cyc[0] - log_cyc[0] : -1;
    n_checks++; if (e0 != BUSY_TIMEOUT) $display("FAIL to_err_delay: got %0d expected %0d", e0, BUSY_TIMEOUT); else n_pass++;
    r1 = (err_cyc.size() > 0 && log_cyc.size() > 1) ? log_cyc[1] - err_cyc[0] : -1;
    n_checks++; if (r1 != 2) $display("FAIL to_regrant_delay: got %0d expected 2", r1); else n_pass++;
    clear_queues(); drive_reqs();
    run_traffic(100, 0, done);
    n_checks++; if (err_cyc.size() != 2) $display("FAIL to_err_count: got %0d expected 2", err_cyc.size()); else n_pass++;
    e1 = (err_cyc.size() > 1 && log_cyc.size() > 1) ? err_cyc[1] - log_cyc[1] : -1;
    n_checks++; if (e1 != BUSY_TIMEOUT) $display("FAIL to_err2_delay: got %0d expected %0d", e1, BUSY_TIMEOUT); else n_pass++;
    n_checks++; if (ack_owner.size() != 0) $display("FAIL to_no_ack: got %0d acks expected 0", ack_owner.size()); else n_pass++;
    m_ptr = 2;
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    clear_logs(); clear_queues();
    qlen[2] = 1; qmem[2][0] = 8'h66; drive_reqs();
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (ack_owner.size() > 0) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL mid_ack_seen: got no ack expected ack"); else n_pass++;
    step(); step();
    hold_busy = 1'b1; busy_tx = 1'b1;
    nRst = 1'b1;
    step();
    nRst = 1'b0; inflight = 1'b0;
    n_checks++; if (grant !== '0) $display("FAIL mid_grant: got %b expected 0", grant); else n_pass++;
    n_checks++; if (ack !== '0) $display("FAIL mid_ack: got %b expected 0", ack); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mid_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (transmit !== 1'b0) $display("FAIL mid_transmit: got %b expected 0", transmit); else n_pass++;
    n_checks++; if (data_tx !== 8'h00) $display("FAIL mid_data_tx: got %h expected 00", data_tx); else n_pass++;
    clear_logs();
    qhead[1] = 0; qlen[1] = 1; qmem[1][0] = 8'h71;
    qhead[3] = 0; qlen[3] = 1; qmem[3][0] = 8'h73;
    drive_reqs();
    repeat (6) step();
    n_checks++; if (log_owner.size() != 0) $display("FAIL mid_launch_while_busy: got %0d expected 0", log_owner.size()); else n_pass++;
    hold_busy = 1'b0;
    m_ptr = 0;
    model_sequence();
    run_traffic(300, 0, done);
    n_checks++; if (!done) $display("FAIL mid_done: got not idle expected idle"); else n_pass++;
    compare_sequence("mid");
  endtask

  task automatic test_random();
    bit done;
    int total;
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      total = 0;
      for (int i = 0; i < N; i++) begin
        qhead[i] = 0;
        qlen[i]  = int'($urandom_range(0, 3));
        burst[i] = bit'($urandom_range(0, 1));
        for (int j = 0; j < qlen[i]; j++) qmem[i][j] = 8'($urandom);
        total += qlen[i];
      end
      if (total == 0) begin qlen[0] = 1; qmem[0][0] = 8'($urandom); end
      model_sequence();
      drive_reqs();
      run_traffic(1000, 0, done);
      n_checks++; if (!done) $display("FAIL rand%0d_done: got not idle expected idle", r); else n_pass++;
      compare_sequence($sformatf("rand%0d", r));
    end
    clear_queues(); drive_reqs();
  endtask

  task automatic test_protocol();
    n_checks++;
    if (proto_viol != 0) $display("FAIL protocol: got %0d violations expected 0", proto_viol);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; proto_viol = 0;
    busy_cnt = 0; pending = 1'b0; hold_busy = 1'b0; model_en = 1'b1; inflight = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) for (int j = 0; j < 16; j++) qmem[i][j] = 8'h00;
    clear_queues();
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_burst();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit path of the `uart` block among `N` byte producers. It sequences the uart `transmit`/`data_tx`/`busy_tx` handshake, so each accepted byte is launched exactly once. It supports locked multi-byte bursts and recovers from a uart that never asserts `busy_tx`. It sits between the system's message sources (command responder, debug logger, etc.) and `uart`.

## Interface

Parameters:
- `N`, 4: number of requesters, legal range 2..8.
- `BUSY_TIMEOUT`, 16: cycles to wait for `busy_tx` to rise after a launch before declaring an error; minimum 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `nRst`  in  1  synchronous, active-high reset. `nRst=1` at a rising edge resets the block.
- `req`  in  N  per-requester byte request; held high until `ack`.
- `lock`  in  N  per-requester burst lock; sampled at end of each byte.
- `data`  in  8*N  byte for requester i on `data[8i+7:8i]`; stable while `req[i]` high.
- `grant`  out  N  one-hot current owner, all-zero when idle.
- `ack`  out  N  one-cycle pulse: byte of requester i accepted by uart.
- `err`  out  1  one-cycle pulse on busy timeout.
- `transmit`  out  1  to `uart.transmit`; one-cycle launch pulse.
- `data_tx`  out  8  to `uart.data_tx`.
- `busy_tx`  in  1  from `uart.busy_tx`.

## Operation

- State: `IDLE`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`. There is a rotation pointer `ptr` of width ceil(log2 N). There is a timeout counter wide enough for `BUSY_TIMEOUT`.
- `IDLE`: when `busy_tx=0` and any `req` is high, select the first i with `req[i]=1`, searching `ptr, ptr+1, …` modulo N.
  - Set `grant` one-hot i.
  - Latch `data_tx <= data[i]`.
  - Go to `LAUNCH`.
  - If `busy_tx=1` (e.g. after reset mid-frame), stay in `IDLE`.
- `LAUNCH`: `transmit=1` for this cycle only. Clear the counter and go to `WAIT_BUSY`.
- `WAIT_BUSY`:
  - If `busy_tx=1`: pulse `ack[i]` and go to `WAIT_DONE`.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT-1`:
    - Pulse `err`; no `ack`.
    - Clear `grant` and set `ptr <= i+1` (mod N).
    - Go to `IDLE`.
- `WAIT_DONE`: wait for `busy_tx=0`. Then:
  - If `lock[i]=1` and `req[i]=1`: keep the grant, latch `data_tx <= data[i]`, and go to `LAUNCH` (burst continues; other requesters are not considered).
  - Else: clear `grant`, set `ptr <= i+1` (mod N), and go to `IDLE`.
- `data_tx` holds its value from latch until the next latch; it never changes while `busy_tx=1`.
- A requester dropping `req` after grant but before `ack` does not cancel the byte. The latched byte is sent and `ack` still pulses.
- `ack` and `err` are mutually exclusive and are never asserted for the same byte.
- Pointer wrap: `ptr=N-1` advances to 0.

## Timing

- Reset values: `grant=0`, `ack=0`, `err=0`, `transmit=0`, `data_tx=8'h00`, `ptr=0`, state `IDLE`, counter 0.
- Reset mid-operation returns to `IDLE` at the next edge. No `ack` or `err` is issued for the aborted byte.
- Request to launch:
  - `req` sampled high at edge E (in `IDLE`, `busy_tx=0`) gives `grant`/`data_tx` valid after E.
  - `transmit` is high during the cycle after E+1 (registered), i.e. two edges after request sampling.
- `ack` is high for the one cycle following the edge that samples `busy_tx=1` in `WAIT_BUSY`.
- Burst back-to-back: relaunch `transmit` occurs 2 cycles after `busy_tx` is sampled low.
- Timeout: `err` pulses exactly `BUSY_TIMEOUT` cycles after the `transmit` cycle if `busy_tx` stays 0.
- Simultaneous requests are resolved only in `IDLE`. Requests arriving during a transfer wait without loss.

## Test plan

Bench uart model: `busy_tx` rises 1 cycle after `transmit`, falls 10 cycles later; check exactly one `transmit` per byte.

1. Single requester: `req[0]=1`, `data[7:0]=8'h55` -> `grant=4'b0001`, one `transmit` pulse with `data_tx=8'h55`, exactly one `ack[0]` pulse, then `grant=0`.
2. All of `req[3:0]` high after reset, with data 8'h10..8'h13 -> launch order 0,1,2,3 with `data_tx` 8'h10,8'h11,8'h12,8'h13; each `ack` once.
3. Fairness: `req[0]` and `req[2]` held high continuously, 6 bytes -> grant sequence 0,2,0,2,0,2.
4. Burst: `req[1]` with `lock[1]=1` for bytes 8'hA1,8'hA2,8'hA3 (lock dropped with the last `ack`), `req[0]` high throughout -> A1,A2,A3 sent consecutively from requester 1, then requester 0 granted.
5. Timeout: model tied `busy_tx=0`, `req[0]` and `req[1]` high -> `err` pulses 16 cycles after the `transmit` cycle, no `ack[0]`, requester 1 then granted.
6. Reset mid-frame: `nRst=1` for one cycle in `WAIT_DONE` while the model holds `busy_tx=1` -> all outputs 0 the next cycle; no `transmit` until `busy_tx` has fallen; then normal arbitration from `ptr=0`.
